// File: rtl/measure_intval_mp.sv
`timescale 1ns/1ps
// Multiphase time-interval meter: NPH phase-clocked gated counters summed over a
// programmable number of sig_a intervals, with start/busy control and a valid/ready result.
module measure_intval_mp #(
    parameter int NPH   = 4,
    parameter int CNT_W = 24,
    parameter int AVG_W = 8,
    parameter int SUM_W = CNT_W + 3
) (
    input  logic             clk_0,
    input  logic             rst,
    input  logic [NPH-2:0]   clk_ph,
    input  logic             sig_a,
    input  logic             sig_b,
    input  logic             mode,
    input  logic [AVG_W-1:0] avg_cycles,
    input  logic             start,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SUM_W-1:0] res_sum,
    output logic [AVG_W-1:0] res_n,
    output logic             res_ovf
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SYNC, S_RUN, S_SETTLE, S_SUM, S_DONE
    } state_t;

    localparam logic [AVG_W-1:0] AVG_ONE = AVG_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic             r_a_meta;
    logic             r_a_s;
    logic             r_a_d;
    logic             w_fall_a;
    logic             r_mode;
    logic [AVG_W-1:0] r_avg;
    logic [AVG_W-1:0] r_n;
    logic [AVG_W-1:0] w_n_inc;
    logic [1:0]       r_tmr;
    logic             r_clr;
    logic             r_armed;
    logic             w_gate;
    logic             w_cnt_rst;
    logic [CNT_W-1:0] w_cnt [NPH];
    logic [NPH-1:0]   w_ovf;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] r_res_sum;
    logic [AVG_W-1:0] r_res_n;
    logic             r_res_ovf;

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            r_a_meta <= 1'b0;
            r_a_s    <= 1'b0;
            r_a_d    <= 1'b0;
        end else begin
            r_a_meta <= sig_a;
            r_a_s    <= r_a_meta;
            r_a_d    <= r_a_s;
        end
    end

    assign w_fall_a = r_a_d & ~r_a_s;
    assign w_n_inc  = r_n + AVG_ONE;

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: default assignment first so the combinational block never infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start)                 w_state_next = S_CLR;
            S_CLR:    if (r_tmr == 2'd1)         w_state_next = S_SYNC;
            S_SYNC:   if (w_fall_a)              w_state_next = S_RUN;
            S_RUN:    if (w_fall_a && (w_n_inc == r_avg)) w_state_next = S_SETTLE;
            S_SETTLE: if (r_tmr == 2'd3)         w_state_next = S_SUM;
            S_SUM:                               w_state_next = S_DONE;
            S_DONE:   if (res_ready)             w_state_next = S_IDLE;
            default:                             w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        res_valid = (r_state == S_DONE);
    end

    // clr and armed follow the next state so they are exact registered windows.
    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            r_tmr     <= 2'd0;
            r_clr     <= 1'b0;
            r_armed   <= 1'b0;
            r_mode    <= 1'b0;
            r_avg     <= AVG_ONE;
            r_n       <= '0;
            r_res_sum <= '0;
            r_res_n   <= '0;
            r_res_ovf <= 1'b0;
        end else begin
            r_tmr   <= (w_state_next != r_state) ? 2'd0 : r_tmr + 2'd1;
            r_clr   <= (w_state_next == S_CLR);
            r_armed <= (w_state_next == S_RUN);
            if (r_state == S_IDLE && start) begin
                r_mode <= mode;
                r_avg  <= (avg_cycles == '0) ? AVG_ONE : avg_cycles;
            end
            if (r_state == S_SYNC)
                r_n <= '0;
            else if (r_state == S_RUN && w_fall_a)
                r_n <= w_n_inc;
            if (r_state == S_SUM) begin
                r_res_sum <= w_sum;
                r_res_n   <= r_n;
                r_res_ovf <= |w_ovf;
            end
        end
    end

    // Gate is built from the raw asynchronous inputs; armed only changes while sig_a is low.
    assign w_gate    = r_armed & sig_a & (r_mode | ~sig_b);
    assign w_cnt_rst = rst | r_clr;

    for (genvar k = 0; k < NPH; k++) begin : g_ph
        logic             w_clk;
        logic [CNT_W-1:0] r_cnt;
        logic             r_ovf;

        if (k == 0) begin : g_ref
            assign w_clk = clk_0;
        end else begin : g_lag
            assign w_clk = clk_ph[k-1];
        end

        always_ff @(posedge w_clk or posedge w_cnt_rst) begin
            if (w_cnt_rst) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_gate) begin
                if (r_cnt == CNT_MAX) r_ovf <= 1'b1;
                else                  r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_cnt[k] = r_cnt;
        assign w_ovf[k] = r_ovf;
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NPH; k++) w_sum = w_sum + SUM_W'(w_cnt[k]);
    end

    assign res_sum = r_res_sum;
    assign res_n   = r_res_n;
    assign res_ovf = r_res_ovf;
endmodule

// File: tb/tb_measure_intval_mp.sv
`timescale 1ns/1ps
// Directed bench for measure_intval_mp: a default instance and a CNT_W=6 instance
// share the 4 phase clocks and a 1 us sig_a / 200 ns sig_a&~sig_b stimulus.
module tb_measure_intval_mp;
    localparam int NPH     = 4;
    localparam int CNT_W   = 24;
    localparam int AVG_W   = 8;
    localparam int SUM_W   = CNT_W + 3;
    localparam int CNT_W_S = 6;
    localparam int SUM_W_S = CNT_W_S + 3;

    logic               clk_0 = 1'b0;
    logic               ph1 = 1'b0;
    logic               ph2 = 1'b0;
    logic               ph3 = 1'b0;
    logic [NPH-2:0]     clk_ph;
    logic               rst;
    logic               sig_a = 1'b0;
    logic               sig_b = 1'b0;
    logic               mode;
    logic [AVG_W-1:0]   avg_cycles;
    logic               start;
    logic               start_s;
    logic               res_ready;
    logic               res_ready_s;
    logic               busy, busy_s;
    logic               res_valid, res_valid_s;
    logic [SUM_W-1:0]   res_sum;
    logic [SUM_W_S-1:0] res_sum_s;
    logic [AVG_W-1:0]   res_n, res_n_s;
    logic               res_ovf, res_ovf_s;

    int n_vec = 0;
    int n_bad = 0;

    assign clk_ph = {ph3, ph2, ph1};

    measure_intval_mp #(.NPH(NPH), .CNT_W(CNT_W), .AVG_W(AVG_W), .SUM_W(SUM_W)) dut (
        .clk_0(clk_0), .rst(rst), .clk_ph(clk_ph), .sig_a(sig_a), .sig_b(sig_b),
        .mode(mode), .avg_cycles(avg_cycles), .start(start), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_n(res_n), .res_ovf(res_ovf)
    );

    measure_intval_mp #(.NPH(NPH), .CNT_W(CNT_W_S), .AVG_W(AVG_W), .SUM_W(SUM_W_S)) dut_sat (
        .clk_0(clk_0), .rst(rst), .clk_ph(clk_ph), .sig_a(sig_a), .sig_b(sig_b),
        .mode(mode), .avg_cycles(avg_cycles), .start(start_s), .busy(busy_s),
        .res_valid(res_valid_s), .res_ready(res_ready_s), .res_sum(res_sum_s),
        .res_n(res_n_s), .res_ovf(res_ovf_s)
    );

    // 100 MHz reference; phase k rises 2.5*k ns after clk_0.
    initial forever #5 clk_0 = ~clk_0;
    initial begin #2.5; forever #5 ph1 = ~ph1; end
    initial begin #5.0; forever #5 ph2 = ~ph2; end
    initial begin #7.5; forever #5 ph3 = ~ph3; end

    // sig_a: 1 us period, 50 % duty; sig_b rises 200 ns after sig_a. Offset keeps edges off clock edges.
    initial begin
        #1.3;
        forever begin
            sig_a = 1'b1;
            #200 sig_b = 1'b1;
            #300 sig_a = 1'b0;
            sig_b = 1'b0;
            #500;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                         input int tol);
        int diff;
        n_vec++;
        diff = (got > exp) ? int'(got - exp) : int'(exp - got);
        if (diff > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic kick(input bit use_s, input logic m, input logic [AVG_W-1:0] a);
        @(negedge clk_0);
        mode       = m;
        avg_cycles = a;
        if (use_s) start_s = 1'b1;
        else       start   = 1'b1;
        @(negedge clk_0);
        start   = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input bit use_s);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_0);
            if (use_s ? res_valid_s : res_valid) break;
        end
        check(tag, 32'(use_s ? res_valid_s : res_valid), 1, 0);
    endtask

    task automatic accept(input bit use_s);
        @(negedge clk_0);
        if (use_s) res_ready_s = 1'b1;
        else       res_ready   = 1'b1;
        @(negedge clk_0);
        res_ready   = 1'b0;
        res_ready_s = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        start_s     = 1'b0;
        res_ready   = 1'b0;
        res_ready_s = 1'b0;
        mode        = 1'b0;
        avg_cycles  = 8'd8;
        repeat (3) @(negedge clk_0);
        check("rst_busy",  32'(busy), 0, 0);
        check("rst_valid", 32'(res_valid), 0, 0);
        check("rst_sum",   32'(res_sum), 0, 0);
        check("rst_n",     32'(res_n), 0, 0);
        check("rst_ovf",   32'(res_ovf), 0, 0);
        rst = 1'b0;
        @(negedge clk_0);
        check("idle_busy", 32'(busy), 0, 0);

        // Mode 0, 8 intervals of 200 ns at 400 MHz effective.
        kick(1'b0, 1'b0, 8'd8);
        check("s1_busy", 32'(busy), 1, 0);
        wait_valid("s1_valid", 1'b0);
        check("s1_sum", 32'(res_sum), 640, 4);
        check("s1_n",   32'(res_n), 8, 0);
        check("s1_ovf", 32'(res_ovf), 0, 0);
        accept(1'b0);
        check("s1_valid_drop", 32'(res_valid), 0, 0);
        check("s1_idle",       32'(busy), 0, 0);

        // Mode 1 (500 ns pulses); result held 50 cycles with a stray start pulse.
        kick(1'b0, 1'b1, 8'd8);
        wait_valid("s2_valid", 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_0);
            start = (i == 20);
            check("s2_hold_valid", 32'(res_valid), 1, 0);
            check("s2_hold_sum",   32'(res_sum), 1600, 4);
        end
        start = 1'b0;
        check("s2_n",   32'(res_n), 8, 0);
        check("s2_ovf", 32'(res_ovf), 0, 0);
        accept(1'b0);
        check("s2_valid_drop", 32'(res_valid), 0, 0);
        check("s2_idle",       32'(busy), 0, 0);
        @(negedge clk_0);
        check("s2_start_dropped", 32'(busy), 0, 0);

        // avg_cycles = 0 counts one interval; start alongside the handshake is ignored.
        kick(1'b0, 1'b0, 8'd0);
        wait_valid("s3_valid", 1'b0);
        check("s3_sum", 32'(res_sum), 80, 4);
        check("s3_n",   32'(res_n), 1, 0);
        @(negedge clk_0);
        res_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk_0);
        res_ready = 1'b0;
        start     = 1'b0;
        check("s3_valid_drop", 32'(res_valid), 0, 0);
        check("s3_hs_start",   32'(busy), 0, 0);
        @(negedge clk_0);
        check("s3_hs_start2",  32'(busy), 0, 0);

        // CNT_W = 6: 160 gated edges per phase saturate each counter at 63.
        kick(1'b1, 1'b0, 8'd8);
        wait_valid("s4_valid", 1'b1);
        check("s4_sum", 32'(res_sum_s), 252, 0);
        check("s4_n",   32'(res_n_s), 8, 0);
        check("s4_ovf", 32'(res_ovf_s), 1, 0);
        accept(1'b1);
        check("s4_valid_drop", 32'(res_valid_s), 0, 0);
        check("s4_idle",       32'(busy_s), 0, 0);

        // Reset during RUN after 3 counted intervals, then a clean measurement.
        @(posedge sig_a);
        kick(1'b0, 1'b0, 8'd8);
        repeat (4) @(negedge sig_a);
        #100;
        check("rr_run_busy", 32'(busy), 1, 0);
        rst = 1'b1;
        #3;
        check("rr_busy",  32'(busy), 0, 0);
        check("rr_valid", 32'(res_valid), 0, 0);
        check("rr_sum",   32'(res_sum), 0, 0);
        @(negedge clk_0);
        rst = 1'b0;
        @(negedge clk_0);
        check("rr_idle", 32'(busy), 0, 0);
        kick(1'b0, 1'b0, 8'd8);
        wait_valid("rr_valid2", 1'b0);
        check("rr_sum2", 32'(res_sum), 640, 4);
        check("rr_n2",   32'(res_n), 8, 0);
        check("rr_ovf2", 32'(res_ovf), 0, 0);
        accept(1'b0);
        check("rr_valid_drop", 32'(res_valid), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
